// File: rtl/f3_pkg.sv
// Shared types for the function-3 sliding-tile executor: instruction codes, FSM states,
// move directions and the solved board pattern.
package f3_pkg;

  localparam logic [3:0] INSTR_NONE     = 4'd0;
  localparam logic [3:0] INSTR_NORTH    = 4'd1;
  localparam logic [3:0] INSTR_EAST     = 4'd2;
  localparam logic [3:0] INSTR_WEST     = 4'd3;
  localparam logic [3:0] INSTR_SOUTH    = 4'd4;
  localparam logic [3:0] INSTR_SCRAMBLE = 4'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SWAP     = 2'd1,
    SCRAMBLE = 2'd2
  } state_t;

  // Encoding matches lfsr[1:0] so scramble can use the LFSR bits directly.
  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_W = 2'd2,
    DIR_S = 2'd3
  } dir_t;

  typedef logic [15:0][3:0] board_t;

  // Element i holds tile i+1; element 15 is the blank.
  localparam board_t SOLVED_BOARD = 64'h0FED_CBA9_8765_4321;

  typedef struct packed {
    logic       ok;
    logic [1:0] row;
    logic [1:0] col;
  } target_t;

  function automatic target_t move_target(input logic [1:0] row,
                                          input logic [1:0] col,
                                          input dir_t       dir);
    target_t t;
    t.ok  = 1'b0;
    t.row = row;
    t.col = col;
    case (dir)
      DIR_N: begin t.ok = (row != 2'd0); t.row = row - 2'd1; end
      DIR_S: begin t.ok = (row != 2'd3); t.row = row + 2'd1; end
      DIR_W: begin t.ok = (col != 2'd0); t.col = col - 2'd1; end
      DIR_E: begin t.ok = (col != 2'd3); t.col = col + 2'd1; end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/f3_lfsr16.sv
// Free-running 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11; advances every cycle.
// Seed must be non-zero; the sequence then never reaches zero.
module f3_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else begin
      r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/f3_move_exec.sv
// Executes one keypad move (or an LFSR-driven scramble) on a 4x4 sliding-tile board.
// Move lands 2 edges after set is first sampled; key edges arriving while busy are dropped.
module f3_move_exec
  import f3_pkg::*;
#(
  parameter int unsigned SCRAMBLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        set,
  input  logic [3:0]  instruction,
  input  logic [3:0]  rd_addr,
  output logic [3:0]  rd_tile,
  output logic [1:0]  blank_row,
  output logic [1:0]  blank_col,
  output logic        busy,
  output logic [15:0] move_count,
  output logic        solved
);

  localparam logic [15:0] SCR_LOAD = 16'(SCRAMBLE_MOVES);

  board_t      r_board;
  state_t      r_state;
  dir_t        r_dir;
  logic        r_set_q;
  logic [15:0] r_cnt;
  logic [15:0] r_move_count;
  logic [1:0]  r_blank_row;
  logic [1:0]  r_blank_col;
  logic        r_busy;
  logic        r_solved;

  logic [15:0] w_lfsr;
  logic        w_lfsr_unused;
  dir_t        w_dir;
  target_t     w_tgt;
  logic [3:0]  w_blank_idx;
  logic [3:0]  w_tgt_idx;
  logic        w_accept;
  logic        w_do_move;

  f3_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .o_state (w_lfsr)
  );

  assign w_lfsr_unused = ^w_lfsr[15:2];

  // Scramble takes its direction from the LFSR each cycle; a user move uses the latched one.
  assign w_dir       = (r_state == SCRAMBLE) ? dir_t'(w_lfsr[1:0]) : r_dir;
  assign w_tgt       = move_target(r_blank_row, r_blank_col, w_dir);
  assign w_blank_idx = {r_blank_row, r_blank_col};
  assign w_tgt_idx   = {w_tgt.row, w_tgt.col};
  assign w_accept    = set & ~r_set_q & (r_state == IDLE);
  assign w_do_move   = w_tgt.ok & ((r_state == SWAP) | (r_state == SCRAMBLE));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_board      <= SOLVED_BOARD;
      r_state      <= IDLE;
      r_dir        <= DIR_N;
      r_set_q      <= 1'b0;
      r_cnt        <= '0;
      r_move_count <= '0;
      r_blank_row  <= 2'd3;
      r_blank_col  <= 2'd3;
      r_busy       <= 1'b0;
      r_solved     <= 1'b1;
    end else begin
      r_set_q  <= set;
      r_solved <= (r_board == SOLVED_BOARD);

      if (w_do_move) begin
        r_board[w_tgt_idx]   <= 4'h0;
        r_board[w_blank_idx] <= r_board[w_tgt_idx];
        r_blank_row          <= w_tgt.row;
        r_blank_col          <= w_tgt.col;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (instruction >= INSTR_NORTH && instruction <= INSTR_SOUTH) begin
              r_dir   <= dir_t'(instruction[1:0] - 2'd1);
              r_state <= SWAP;
              r_busy  <= 1'b1;
            end else if (instruction == INSTR_SCRAMBLE) begin
              r_cnt        <= SCR_LOAD;
              r_move_count <= '0;
              r_state      <= SCRAMBLE;
              r_busy       <= 1'b1;
            end
          end
        end
        SWAP: begin
          if (w_tgt.ok && r_move_count != 16'hFFFF) begin
            r_move_count <= r_move_count + 16'd1;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        SCRAMBLE: begin
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_tile    = r_board[rd_addr];
  assign blank_row  = r_blank_row;
  assign blank_col  = r_blank_col;
  assign busy       = r_busy;
  assign move_count = r_move_count;
  assign solved     = r_solved;

endmodule

// File: tb/tb_f3_move_exec.sv
// Directed + randomized bench for f3_move_exec against a board-level model
// (tile array, pending action, scramble budget) advanced once per clock edge.
`timescale 1ns/1ps
module tb_f3_move_exec;

  localparam int          SCR  = 64;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        set;
  logic [3:0]  instruction;
  logic [3:0]  rd_addr;
  logic [3:0]  rd_tile;
  logic [1:0]  blank_row;
  logic [1:0]  blank_col;
  logic        busy;
  logic [15:0] move_count;
  logic        solved;

  f3_move_exec #(.SCRAMBLE_MOVES(SCR), .LFSR_SEED(SEED)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .set         (set),
    .instruction (instruction),
    .rd_addr     (rd_addr),
    .rd_tile     (rd_tile),
    .blank_row   (blank_row),
    .blank_col   (blank_col),
    .busy        (busy),
    .move_count  (move_count),
    .solved      (solved)
  );

  always #10 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  // Reference model
  int          m_board[16];
  int          m_pend;
  int          m_left;
  int          m_moves;
  bit          m_set_q;
  bit          m_solved;
  logic [15:0] m_lfsr;

  function automatic int find_blank();
    for (int i = 0; i < 16; i++) if (m_board[i] == 0) return i;
    return -1;
  endfunction

  function automatic bit board_solved();
    for (int i = 0; i < 15; i++) if (m_board[i] != i + 1) return 1'b0;
    return (m_board[15] == 0);
  endfunction

  function automatic bit try_move(input int d);
    int b, r, c, nr, nc;
    b = find_blank(); r = b / 4; c = b % 4; nr = r; nc = c;
    case (d)
      0: nr = r - 1;
      1: nc = c + 1;
      2: nc = c - 1;
      default: nr = r + 1;
    endcase
    if (nr < 0 || nr > 3 || nc < 0 || nc > 3) return 1'b0;
    m_board[b] = m_board[nr*4 + nc];
    m_board[nr*4 + nc] = 0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_board[i] = i + 1;
    m_board[15] = 0;
    m_pend = -1; m_left = 0; m_moves = 0;
    m_set_q = 1'b0; m_solved = 1'b1; m_lfsr = SEED;
  endtask

  task automatic tick();
    bit pre_solved;
    @(posedge sysclk);
    if (rst_n) begin
      pre_solved = board_solved();
      if (m_left > 0) begin
        void'(try_move(int'(m_lfsr[1:0])));
        m_left--;
      end else if (m_pend >= 0) begin
        if (try_move(m_pend) && m_moves < 65535) m_moves++;
        m_pend = -1;
      end else if (set && !m_set_q) begin
        if (instruction >= 4'd1 && instruction <= 4'd4) m_pend = int'(instruction) - 1;
        else if (instruction == 4'd5) begin m_left = SCR; m_moves = 0; end
      end
      m_set_q  = set;
      m_solved = pre_solved;
      m_lfsr   = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int b;
    b = find_blank();
    chk({tag, ".busy"},  32'(busy),       32'((m_pend >= 0) || (m_left > 0)));
    chk({tag, ".brow"},  32'(blank_row),  32'(b / 4));
    chk({tag, ".bcol"},  32'(blank_col),  32'(b % 4));
    chk({tag, ".moves"}, 32'(move_count), 32'(m_moves));
    chk({tag, ".solved"},32'(solved),     32'(m_solved));
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #0.25;
      chk($sformatf("%s.tile%0d", tag, i), 32'(rd_tile), 32'(m_board[i]));
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input string tag);
    set = 1'b1; instruction = code;
    for (int k = 0; k < hold; k++) begin tick(); check_state(tag); end
    set = 1'b0;
    tick(); check_state(tag);
    tick(); check_state(tag);
  endtask

  task automatic scramble_and_count(input string tag, input bool_noise);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    int held;

    // 1. reset state
    rst_n = 1'b0; set = 1'b0; instruction = 4'd0; rd_addr = 4'd0;
    model_reset();
    #25;
    check_state("reset");
    chk("reset.lfsr", 32'(dut.w_lfsr), 32'(SEED));
    rst_n = 1'b1;
    tick(); check_state("post_reset");

    // 2. held West key yields exactly one move, busy for exactly one cycle
    set = 1'b1; instruction = 4'd3; cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); check_state("west_hold");
      if (busy) cnt++;
    end
    set = 1'b0;
    tick(); check_state("west_rel");
    chk("west.busy_cycles", 32'(cnt), 32'd1);
    chk("west.brow", 32'(blank_row), 32'd3);
    chk("west.bcol", 32'(blank_col), 32'd2);
    chk("west.moves", 32'(move_count), 32'd1);

    // 3. off-board East/South from reset, then North
    rst_n = 1'b0; model_reset(); #3; rst_n = 1'b1;
    press(4'd2, 3, "east_off");
    press(4'd4, 2, "south_off");
    chk("off.moves", 32'(move_count), 32'd0);
    press(4'd1, 1, "north");
    rd_addr = 4'd15; #0.25;
    chk("north.tile15", 32'(rd_tile), 32'd12);
    chk("north.brow", 32'(blank_row), 32'd2);

    // 4. scramble: busy exactly SCR cycles; key noise during busy must be ignored
    set = 1'b1; instruction = 4'd5;
    tick(); check_state("scr_accept");
    set = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      cnt++;
      set = 1'(($urandom_range(0, 1)));
      instruction = 4'($urandom_range(1, 4));
      tick(); check_state("scr_run");
    end
    chk("scr.busy_cycles", 32'(cnt), 32'(SCR));
    set = 1'b0;
    tick(); check_state("scr_done");
    tick(); check_state("scr_done2");

    // 5. codes 7 and 0 do nothing
    cnt = int'(move_count);
    press(4'd7, 2, "code7");
    press(4'd0, 2, "code0");
    chk("ignored.moves", 32'(move_count), 32'(cnt));

    // 6. randomized presses, occasional scramble, random hold and gap
    for (int n = 0; n < 120; n++) begin
      held = $urandom_range(0, 19);
      set = 1'b1;
      if (held == 0)      instruction = 4'd5;
      else if (held < 4)  instruction = 4'($urandom_range(0, 15));
      else                instruction = 4'($urandom_range(1, 4));
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin tick(); check_state("rnd_hold"); end
      set = 1'b0;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin tick(); check_state("rnd_gap"); end
      for (int k = 0; k < 200; k++) begin
        if (!busy) break;
        tick(); check_state("rnd_drain");
      end
    end

    // 7. reset asserted 20 cycles into a scramble aborts it
    set = 1'b0; tick(); check_state("pre_mid");
    set = 1'b1; instruction = 4'd5;
    tick(); check_state("mid_accept");
    set = 1'b0;
    for (int k = 0; k < 20; k++) begin tick(); check_state("mid_run"); end
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("mid_reset");
    chk("mid_reset.lfsr", 32'(dut.w_lfsr), 32'(SEED));
    tick(); check_state("mid_reset_hold");
    #5; rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); check_state("after_reset"); end
    press(4'd3, 2, "final_west");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
